// File: rtl/branch_pkg.sv
// Shared definitions for the branch comparator scheduler.
// Contents:
//   - funct3 encodings of the conditional branches
//   - scheduler state enum (IDLE -> CMP -> RSP)
//   - requester id enum (branch unit / ALU set-less-than path)
//   - helper that derives the comparator's unsigned-mode bit from a branch funct3
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RSP  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_BR  = 1'b0,
        REQ_SLT = 1'b1
    } req_id_t;

    // BLTU/BGEU (and the illegal 01x codes) carry funct3[1] = 1. The
    // comparator only needs the unsigned flag; legality is decided later.
    function automatic logic branchIsUnsigned(input logic [2:0] funct3);
        return funct3[1];
    endfunction

endpackage

// File: rtl/branch_cmp_sched_if.sv
// Bundle of the requester handshakes and the comparator bus around
// branch_cmp_sched.
//   slave  : the scheduler (consumes requests and comparator flags,
//            drives dones/results and comparator operands)
//   master : the surrounding core (branch unit, ALU SLT path, comparator)
interface branch_cmp_sched_if #(
    parameter int XLEN = 32
);
    // branch unit
    logic            br_req;
    logic [2:0]      br_funct3;
    logic [XLEN-1:0] br_rs1;
    logic [XLEN-1:0] br_rs2;
    logic            br_done;
    logic            br_taken;
    logic            br_illegal;
    // ALU set-less-than path
    logic            slt_req;
    logic            slt_unsigned;
    logic [XLEN-1:0] slt_a;
    logic [XLEN-1:0] slt_b;
    logic            slt_done;
    logic            slt_result;
    // shared comparator
    logic [XLEN-1:0] cmp_a;
    logic [XLEN-1:0] cmp_b;
    logic            cmp_brun;
    logic            cmp_brlt;
    logic            cmp_breq;

    modport slave (
        input  br_req, br_funct3, br_rs1, br_rs2,
        output br_done, br_taken, br_illegal,
        input  slt_req, slt_unsigned, slt_a, slt_b,
        output slt_done, slt_result,
        output cmp_a, cmp_b, cmp_brun,
        input  cmp_brlt, cmp_breq
    );

    modport master (
        output br_req, br_funct3, br_rs1, br_rs2,
        input  br_done, br_taken, br_illegal,
        output slt_req, slt_unsigned, slt_a, slt_b,
        input  slt_done, slt_result,
        input  cmp_a, cmp_b, cmp_brun,
        output cmp_brlt, cmp_breq
    );

endinterface

// File: rtl/branch_decision.sv
// Combinational branch decision from comparator flags.
// Ports:
//   funct3  in  3  branch funct3
//   lt      in  1  comparator BrLT
//   eq      in  1  comparator BrEq
//   taken   out 1  branch outcome
//   illegal out 1  funct3 is 010/011 (not a branch); taken forced to 0
module branch_decision
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       lt,
    input  logic       eq,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:           taken   = eq;
            F3_BNE:           taken   = !eq;
            F3_BLT,  F3_BLTU: taken   = lt;
            F3_BGE,  F3_BGEU: taken   = !lt;
            default:          illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_cmp_sched.sv
// Time-shares the single branch comparator between the branch unit and the
// ALU set-less-than path.
// A granted request latches its operands onto cmp_a/cmp_b/cmp_brun, the
// comparator flags are sampled one cycle later, and the winner gets a
// one-cycle done pulse with its result the cycle after that
// (IDLE -> CMP -> RSP -> IDLE, one comparison every 3 cycles).
// Contention is resolved round-robin on the last granted requester.
// Ports:
//   clk          in   core clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   bus          slave modport of branch_cmp_sched_if (requests, results,
//                comparator operands and flags)
//   cnt_clr      in   synchronous clear of the statistics counters
//   br_cnt       out  branches resolved (wrapping)
//   br_taken_cnt out  branches taken (wrapping)
module branch_cmp_sched
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_cmp_sched_if.slave bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] br_taken_cnt
);

    state_t          stateReg,       stateNext;
    req_id_t         lastWinnerReg,  lastWinnerNext;
    req_id_t         winnerReg,      winnerNext;
    logic [2:0]      funct3Reg,      funct3Next;
    logic [XLEN-1:0] cmpAReg,        cmpANext;
    logic [XLEN-1:0] cmpBReg,        cmpBNext;
    logic            cmpBrunReg,     cmpBrunNext;
    logic            brDoneReg,      brDoneNext;
    logic            brTakenReg,     brTakenNext;
    logic            brIllegalReg,   brIllegalNext;
    logic            sltDoneReg,     sltDoneNext;
    logic            sltResultReg,   sltResultNext;
    logic [CNT_W-1:0] brCntReg,      brCntNext;
    logic [CNT_W-1:0] brTakenCntReg, brTakenCntNext;

    logic grantBr;
    logic grantSlt;
    logic decTaken;
    logic decIllegal;

    // The branch unit wins alone, or under contention when SLT went last.
    assign grantBr  = bus.br_req && (!bus.slt_req || (lastWinnerReg == REQ_SLT));
    assign grantSlt = bus.slt_req && !grantBr;

    // funct3Reg still holds the granted branch's funct3 during CMP; for an
    // SLT grant the decision output is simply ignored.
    branch_decision u_decision (
        .funct3  (funct3Reg),
        .lt      (bus.cmp_brlt),
        .eq      (bus.cmp_breq),
        .taken   (decTaken),
        .illegal (decIllegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg      <= IDLE;
            lastWinnerReg <= REQ_SLT;
            winnerReg     <= REQ_BR;
            funct3Reg     <= 3'b000;
            cmpAReg       <= '0;
            cmpBReg       <= '0;
            cmpBrunReg    <= 1'b0;
            brDoneReg     <= 1'b0;
            brTakenReg    <= 1'b0;
            brIllegalReg  <= 1'b0;
            sltDoneReg    <= 1'b0;
            sltResultReg  <= 1'b0;
            brCntReg      <= '0;
            brTakenCntReg <= '0;
        end else begin
            stateReg      <= stateNext;
            lastWinnerReg <= lastWinnerNext;
            winnerReg     <= winnerNext;
            funct3Reg     <= funct3Next;
            cmpAReg       <= cmpANext;
            cmpBReg       <= cmpBNext;
            cmpBrunReg    <= cmpBrunNext;
            brDoneReg     <= brDoneNext;
            brTakenReg    <= brTakenNext;
            brIllegalReg  <= brIllegalNext;
            sltDoneReg    <= sltDoneNext;
            sltResultReg  <= sltResultNext;
            brCntReg      <= brCntNext;
            brTakenCntReg <= brTakenCntNext;
        end
    end

    always_comb begin
        // Hold everything by default; dones are pulses and default low.
        stateNext      = stateReg;
        lastWinnerNext = lastWinnerReg;
        winnerNext     = winnerReg;
        funct3Next     = funct3Reg;
        cmpANext       = cmpAReg;
        cmpBNext       = cmpBReg;
        cmpBrunNext    = cmpBrunReg;
        brDoneNext     = 1'b0;
        brTakenNext    = brTakenReg;
        brIllegalNext  = brIllegalReg;
        sltDoneNext    = 1'b0;
        sltResultNext  = sltResultReg;
        brCntNext      = brCntReg;
        brTakenCntNext = brTakenCntReg;

        case (stateReg)
            IDLE: begin
                if (grantBr) begin
                    cmpANext       = bus.br_rs1;
                    cmpBNext       = bus.br_rs2;
                    cmpBrunNext    = branchIsUnsigned(bus.br_funct3);
                    funct3Next     = bus.br_funct3;
                    winnerNext     = REQ_BR;
                    lastWinnerNext = REQ_BR;
                    stateNext      = CMP;
                end else if (grantSlt) begin
                    cmpANext       = bus.slt_a;
                    cmpBNext       = bus.slt_b;
                    cmpBrunNext    = bus.slt_unsigned;
                    winnerNext     = REQ_SLT;
                    lastWinnerNext = REQ_SLT;
                    stateNext      = CMP;
                end
            end
            CMP: begin
                // Operands have been stable for a full cycle; the comparator
                // is combinational so its flags are valid at this edge.
                if (winnerReg == REQ_BR) begin
                    brDoneNext    = 1'b1;
                    brTakenNext   = decTaken;
                    brIllegalNext = decIllegal;
                end else begin
                    sltDoneNext   = 1'b1;
                    sltResultNext = bus.cmp_brlt;
                end
                stateNext = RSP;
            end
            RSP: begin
                // br_done is high during this cycle; the statistics count it
                // at the edge that ends the pulse.
                if (brDoneReg) begin
                    brCntNext = brCntReg + CNT_W'(1);
                    if (brTakenReg) begin
                        brTakenCntNext = brTakenCntReg + CNT_W'(1);
                    end
                end
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase

        // A clear coinciding with an increment leaves the counters at 0.
        if (cnt_clr) begin
            brCntNext      = '0;
            brTakenCntNext = '0;
        end
    end

    assign bus.cmp_a      = cmpAReg;
    assign bus.cmp_b      = cmpBReg;
    assign bus.cmp_brun   = cmpBrunReg;
    assign bus.br_done    = brDoneReg;
    assign bus.br_taken   = brTakenReg;
    assign bus.br_illegal = brIllegalReg;
    assign bus.slt_done   = sltDoneReg;
    assign bus.slt_result = sltResultReg;
    assign br_cnt         = brCntReg;
    assign br_taken_cnt   = brTakenCntReg;

endmodule
